bit_serializer: RTL and testbench

Parallel-to-serial feeder for the Moore sequence detector. It accepts WIDTH-bit words over a valid/ready handshake and buffers one word behind the one being shifted. It emits the words as a continuous, gap-free bit stream on `out`, one bit per clock, and that stream drives the detector's `in` port directly. When no data is pending it idles the line low with `out_valid` deasserted.

---
 rtl/serializer_pkg.sv | 27 ++
 rtl/bit_serializer.sv | 112 +++++++++++
 tb/tb_bit_serializer.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/serializer_pkg.sv
// Shared types and helpers for the parallel-to-serial feeder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package serializer_pkg;

    // Widest word the serializer is built for; bit_sel works on this width.
    localparam int MAX_WIDTH     = 32;
    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // First bit to present for a word: bit width-1 when MSB first, else bit 0.
    // Callers zero-extend the word to MAX_WIDTH before passing it in.
    function automatic logic bit_sel(
        input logic [MAX_WIDTH-1:0] word,
        input int                   width,
        input logic                 msb_first
    );
        logic [4:0] top;
        top = 5'(width - 1);
        return msb_first ? word[top] : word[0];
    endfunction

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial feeder: WIDTH-bit words in, gap-free 1 bit/clk stream out.
// Latency: first bit on out one cycle after the accept edge; WIDTH cycles per word.
// Backpressure: one word shifting plus one held; load_ready drops only while hold is full.
module bit_serializer
    import serializer_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             out,
    output logic             out_valid,
    output logic             out_last
);

    localparam int               CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]    CNT_MAX  = CW'(WIDTH - 1);
    localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
    localparam logic             MSB_BIT  = (MSB_FIRST != 0);

    state_t            state;
    logic [WIDTH-1:0]  sh;
    logic [CW-1:0]     cnt;     // bits remaining after the one on out
    logic [WIDTH-1:0]  hold;
    logic              hold_full;
    logic [WIDTH-1:0]  sh_adv;
    logic              accept;

    // Ready comes from registers only, so upstream never sees a valid->ready path.
    assign load_ready = !hold_full;
    assign accept     = load_valid && load_ready;

    // Shift register contents after advancing one bit in the configured direction.
    always_comb begin
        sh_adv = sh;
        if (MSB_BIT) begin
            sh_adv = {sh[WIDTH-2:0], 1'b0};
        end else begin
            sh_adv = {1'b0, sh[WIDTH-1:1]};
        end
    end

    // Control FSM with registered serial outputs; hold->sh refill takes priority
    // over a fresh accept so words leave in acceptance order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            sh        <= '0;
            cnt       <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
            out       <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sh        <= load_data;
                        cnt       <= CNT_MAX;
                        state     <= SHIFT;
                        out       <= bit_sel(MAX_WIDTH'(load_data), WIDTH, MSB_BIT);
                        out_valid <= 1'b1;
                        out_last  <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (cnt != '0) begin
                        // Mid-word: advance, and park any new word in hold.
                        sh       <= sh_adv;
                        cnt      <= cnt - CNT_ONE;
                        out      <= bit_sel(MAX_WIDTH'(sh_adv), WIDTH, MSB_BIT);
                        out_last <= (cnt == CNT_ONE);
                        if (accept) begin
                            hold      <= load_data;
                            hold_full <= 1'b1;
                        end
                    end else if (hold_full) begin
                        // Last bit on the line: splice in the held word, no gap.
                        sh        <= hold;
                        hold_full <= 1'b0;
                        cnt       <= CNT_MAX;
                        out       <= bit_sel(MAX_WIDTH'(hold), WIDTH, MSB_BIT);
                        out_last  <= 1'b0;
                    end else if (accept) begin
                        // Word arriving exactly at the boundary goes straight to sh.
                        sh       <= load_data;
                        cnt      <= CNT_MAX;
                        out      <= bit_sel(MAX_WIDTH'(load_data), WIDTH, MSB_BIT);
                        out_last <= 1'b0;
                    end else begin
                        state     <= IDLE;
                        out       <= 1'b0;
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out       <= 1'b0;
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
`timescale 1ns/1ps
module tb_bit_serializer;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         lv0, lv1;
    logic [W-1:0] ld0, ld1;
    logic         rdy0, rdy1, o0, o1, vld0, vld1, last0, last1;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 0;

    // Reference model: each DUT's future line contents as a queue of bits
    // plus a parallel queue marking the last bit of each word.
    bit qb0[$];
    bit ql0[$];
    bit qb1[$];
    bit ql1[$];

    bit_serializer #(.WIDTH(W), .MSB_FIRST(1)) u_msb (
        .clk(clk), .reset(rst_n), .load_valid(lv0), .load_data(ld0),
        .load_ready(rdy0), .out(o0), .out_valid(vld0), .out_last(last0)
    );

    bit_serializer #(.WIDTH(W), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .reset(rst_n), .load_valid(lv1), .load_data(ld1),
        .load_ready(rdy1), .out(o1), .out_valid(vld1), .out_last(last1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model update per edge: accept if fewer than two words resident, retire
    // the bit shown during the past cycle, then append the accepted word.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qb0.delete(); ql0.delete(); qb1.delete(); ql1.delete();
        end else begin
            bit a0, a1;
            a0 = lv0 && (qb0.size() <= W);
            a1 = lv1 && (qb1.size() <= W);
            if (qb0.size() > 0) begin void'(qb0.pop_front()); void'(ql0.pop_front()); end
            if (qb1.size() > 0) begin void'(qb1.pop_front()); void'(ql1.pop_front()); end
            if (a0) for (int i = 0; i < W; i++) begin qb0.push_back(ld0[W-1-i]); ql0.push_back(i == W-1); end
            if (a1) for (int i = 0; i < W; i++) begin qb1.push_back(ld1[i]);     ql1.push_back(i == W-1); end
        end
    end

    // Compare every output of both DUTs against the model each cycle.
    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            chk("vld0",  vld0,  qb0.size() > 0);
            chk("out0",  o0,    (qb0.size() > 0) ? qb0[0] : 1'b0);
            chk("last0", last0, (qb0.size() > 0) ? ql0[0] : 1'b0);
            chk("rdy0",  rdy0,  qb0.size() <= W);
            chk("vld1",  vld1,  qb1.size() > 0);
            chk("out1",  o1,    (qb1.size() > 0) ? qb1[0] : 1'b0);
            chk("last1", last1, (qb1.size() > 0) ? ql1[0] : 1'b0);
            chk("rdy1",  rdy1,  qb1.size() <= W);
        end
    end

    // Present a word at the current negedge and hold it until the model says
    // it has been accepted; returns at the negedge just after the accept edge.
    task automatic send0(input logic [W-1:0] w);
        int t = 0;
        lv0 = 1'b1; ld0 = w;
        while (!(qb0.size() <= W) && t < 100) begin @(negedge clk); t++; end
        chk("send0_wait", t < 100, 1);
        @(negedge clk);
    endtask

    task automatic send1(input logic [W-1:0] w);
        int t = 0;
        lv1 = 1'b1; ld1 = w;
        while (!(qb1.size() <= W) && t < 100) begin @(negedge clk); t++; end
        chk("send1_wait", t < 100, 1);
        @(negedge clk);
    endtask

    initial begin
        logic [9:0] cd, cv, cl;
        logic [7:0] c8;
        rst_n = 1'b0; lv0 = 0; lv1 = 0; ld0 = '0; ld1 = '0;
        repeat (3) @(negedge clk);
        chk("rst_out0", o0, 0);   chk("rst_vld0", vld0, 0);
        chk("rst_last0", last0, 0); chk("rst_rdy0", rdy0, 1);
        chk("rst_out1", o1, 0);   chk("rst_vld1", vld1, 0);
        chk("rst_rdy1", rdy1, 1);
        rst_n = 1'b1;
        chk_en = 1;
        repeat (2) @(negedge clk);

        // Single word A5, MSB first, with an explicit 10-cycle trace.
        send0(8'hA5); lv0 = 0;
        for (int i = 0; i < 10; i++) begin
            cd[9-i] = o0; cv[9-i] = vld0; cl[9-i] = last0;
            @(negedge clk);
        end
        chk("a5_bits", cd, 10'b1010010100);
        chk("a5_vld",  cv, 10'b1111111100);
        chk("a5_last", cl, 10'b0000000100);
        repeat (3) @(negedge clk);

        // Back-to-back stream A5, 3C, FF: hold fills after the second accept.
        send0(8'hA5);
        send0(8'h3C);
        chk("rdy_after_2nd", rdy0, 0);
        send0(8'hFF); lv0 = 0;
        repeat (30) @(negedge clk);

        // LSB first, 8'h01.
        send1(8'h01); lv1 = 0;
        for (int i = 0; i < 8; i++) begin
            c8[7-i] = o1;
            @(negedge clk);
        end
        chk("lsb01_bits", c8, 8'b10000000);
        repeat (3) @(negedge clk);

        // 8'h80 accepted exactly on the last-bit cycle of 8'h01.
        send0(8'h01); lv0 = 0;
        repeat (7) @(negedge clk);
        chk("boundary_last", last0, 1);
        send0(8'h80); lv0 = 0;
        chk("boundary_rdy", rdy0, 1);
        repeat (20) @(negedge clk);

        // Reset asserted during the 4th bit of F0.
        send0(8'hF0); lv0 = 0;
        repeat (3) @(posedge clk);
        #2;
        chk("pre_rst_vld", vld0, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_out",  o0, 0);
        chk("arst_vld",  vld0, 0);
        chk("arst_last", last0, 0);
        chk("arst_rdy",  rdy0, 1);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rel_rdy", rdy0, 1);
        repeat (12) @(negedge clk);

        // Randomized traffic on both DUTs; data changes even when not accepted.
        for (int i = 0; i < 800; i++) begin
            lv0 = ($urandom_range(0, 9) < 7);
            lv1 = ($urandom_range(0, 9) < 4);
            ld0 = W'($urandom);
            ld1 = W'($urandom);
            @(negedge clk);
        end
        lv0 = 0; lv1 = 0;
        repeat (25) @(negedge clk);
        chk("drain0", vld0, 0);
        chk("drain1", vld1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
